// File: rtl/notas_pkg.sv
// notas_pkg: shared types and constants for the note scheduler.
// Scheduler states, 3-bit note codes and note-owner codes.
package notas_pkg;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    SONANDO = 2'd1,
    PAUSA   = 2'd2
  } estado_t;

  localparam logic [2:0] NOTA_DO      = 3'd0;
  localparam logic [2:0] NOTA_RE      = 3'd1;
  localparam logic [2:0] NOTA_MI      = 3'd2;
  localparam logic [2:0] NOTA_FA      = 3'd3;
  localparam logic [2:0] NOTA_SOL     = 3'd4;
  localparam logic [2:0] NOTA_LA      = 3'd5;
  localparam logic [2:0] NOTA_SI      = 3'd6;
  localparam logic [2:0] NOTA_NINGUNA = 3'd7;

  localparam logic LIBRE = 1'b0;
  localparam logic SEC   = 1'b1;

endpackage

// File: rtl/contador_duracion.sv
// contador_duracion: loadable down counter that stops at zero.
// A load takes priority; otherwise the value decrements until it reaches
// zero and then holds, so it never wraps.
module contador_duracion #(
  parameter int CW = 25
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cargar,
  input  logic [CW-1:0] carga,
  output logic [CW-1:0] valor,
  output logic          cero
);

  logic [CW-1:0] valor_r;

  // Count register: load on request, else decrement down to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valor_r <= '0;
    end else if (cargar) begin
      valor_r <= carga;
    end else if (valor_r != '0) begin
      valor_r <= valor_r - CW'(1);
    end else begin
      valor_r <= valor_r;
    end
  end

  assign valor = valor_r;
  assign cero  = (valor_r == '0);

endmodule

// File: rtl/planificador_notas.sv
// planificador_notas: grants the single tone generator to free-play or the
// song sequencer, one note at a time, DURACION cycles of sound followed by
// SILENCIO cycles of gap. Free-play has fixed priority.
// Optional macro PREEMPCION_EN: a free-play request interrupts a sounding
// sequencer note and restarts the note duration with the free-play note.
module planificador_notas
  import notas_pkg::*;
#(
  parameter int DURACION = 25_000_000,
  parameter int SILENCIO = 2_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       habilitar,
  input  logic       libre_req,
  input  logic [2:0] libre_nota,
  input  logic       sec_req,
  input  logic [2:0] sec_nota,
  output logic       libre_ack,
  output logic       sec_ack,
  output logic [2:0] nota,
  output logic       contar,
  output logic       fuente
);

  localparam int MAXC = (DURACION > SILENCIO) ? DURACION : SILENCIO;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] CARGA_DUR = CW'(DURACION - 1);
  localparam logic [CW-1:0] CARGA_SIL = CW'(SILENCIO - 1);

  estado_t       estado_r, estado_s;
  logic          cargar_s;
  logic [CW-1:0] carga_s;
  logic [CW-1:0] valor_s;
  logic          cero_s;
  logic          preempt_s;

  logic [2:0] nota_r, nota_s;
  logic       contar_r, contar_s;
  logic       fuente_r, fuente_s;
  logic       libre_ack_r, libre_ack_s;
  logic       sec_ack_r, sec_ack_s;

  contador_duracion #(.CW(CW)) u_contador (
    .clk    (clk),
    .reset  (reset),
    .cargar (cargar_s),
    .carga  (carga_s),
    .valor  (valor_s),
    .cero   (cero_s)
  );

`ifdef PREEMPCION_EN
  assign preempt_s = (estado_r == SONANDO) && (fuente_r == SEC) && libre_req && habilitar;
`else
  assign preempt_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_r <= REPOSO;
    end else begin
      estado_r <= estado_s;
    end
  end

  // Next-state and counter load selection.
  always_comb begin
    estado_s = estado_r;
    cargar_s = 1'b0;
    carga_s  = CARGA_DUR;
    case (estado_r)
      REPOSO: begin
        if (habilitar && (libre_req || sec_req)) begin
          estado_s = SONANDO;
          cargar_s = 1'b1;
          carga_s  = CARGA_DUR;
        end else begin
          estado_s = REPOSO;
        end
      end
      SONANDO: begin
        if (preempt_s) begin
          estado_s = SONANDO;
          cargar_s = 1'b1;
          carga_s  = CARGA_DUR;
        end else if (cero_s) begin
          estado_s = PAUSA;
          cargar_s = 1'b1;
          carga_s  = CARGA_SIL;
        end else begin
          estado_s = SONANDO;
        end
      end
      PAUSA: begin
        if (cero_s) begin
          estado_s = REPOSO;
        end else begin
          estado_s = PAUSA;
        end
      end
      default: begin
        estado_s = REPOSO;
      end
    endcase
  end

  // Next values of the registered outputs (grant, note, owner, enable).
  always_comb begin
    nota_s      = nota_r;
    fuente_s    = fuente_r;
    contar_s    = contar_r;
    libre_ack_s = 1'b0;
    sec_ack_s   = 1'b0;
    case (estado_r)
      REPOSO: begin
        if (habilitar && libre_req) begin
          nota_s      = libre_nota;
          fuente_s    = LIBRE;
          contar_s    = 1'b1;
          libre_ack_s = 1'b1;
        end else if (habilitar && sec_req) begin
          nota_s    = sec_nota;
          fuente_s  = SEC;
          contar_s  = 1'b1;
          sec_ack_s = 1'b1;
        end else begin
          contar_s = 1'b0;
        end
      end
      SONANDO: begin
        if (preempt_s) begin
          nota_s      = libre_nota;
          fuente_s    = LIBRE;
          contar_s    = 1'b1;
          libre_ack_s = 1'b1;
        end else if (cero_s) begin
          contar_s = 1'b0;
        end else begin
          contar_s = 1'b1;
        end
      end
      PAUSA: begin
        contar_s = 1'b0;
      end
      default: begin
        contar_s = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nota_r      <= 3'd0;
      contar_r    <= 1'b0;
      fuente_r    <= LIBRE;
      libre_ack_r <= 1'b0;
      sec_ack_r   <= 1'b0;
    end else begin
      nota_r      <= nota_s;
      contar_r    <= contar_s;
      fuente_r    <= fuente_s;
      libre_ack_r <= libre_ack_s;
      sec_ack_r   <= sec_ack_s;
    end
  end

  assign nota      = nota_r;
  assign contar    = contar_r;
  assign fuente    = fuente_r;
  assign libre_ack = libre_ack_r;
  assign sec_ack   = sec_ack_r;

endmodule

// File: tb/tb_planificador_notas.sv
// tb_planificador_notas: directed bench with DURACION=4, SILENCIO=2.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_planificador_notas;

  logic       clk;
  logic       reset;
  logic       habilitar;
  logic       libre_req;
  logic [2:0] libre_nota;
  logic       sec_req;
  logic [2:0] sec_nota;
  logic       libre_ack;
  logic       sec_ack;
  logic [2:0] nota;
  logic       contar;
  logic       fuente;

  int checks = 0;
  int errors = 0;

  planificador_notas #(.DURACION(4), .SILENCIO(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .habilitar  (habilitar),
    .libre_req  (libre_req),
    .libre_nota (libre_nota),
    .sec_req    (sec_req),
    .sec_nota   (sec_nota),
    .libre_ack  (libre_ack),
    .sec_ack    (sec_ack),
    .nota       (nota),
    .contar     (contar),
    .fuente     (fuente)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Checks all five outputs at once.
  task automatic outs(input string tag, input logic la, input logic sa,
                      input logic [2:0] n, input logic c, input logic f);
    check({tag, ".libre_ack"}, {3'd0, libre_ack}, {3'd0, la});
    check({tag, ".sec_ack"},   {3'd0, sec_ack},   {3'd0, sa});
    check({tag, ".nota"},      {1'b0, nota},      {1'b0, n});
    check({tag, ".contar"},    {3'd0, contar},    {3'd0, c});
    check({tag, ".fuente"},    {3'd0, fuente},    {3'd0, f});
  endtask

  initial begin
    reset = 1'b0; habilitar = 1'b1;
    libre_req = 1'b0; libre_nota = 3'd0;
    sec_req = 1'b0; sec_nota = 3'd0;
    cyc(2);
    outs("reset", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    reset = 1'b1;
    cyc(3);
    outs("idle", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Free-play note 3, request held to see the next grant period.
    libre_req = 1'b1; libre_nota = 3'd3;
    cyc(1);
    outs("lib.grant", 1'b1, 1'b0, 3'd3, 1'b1, 1'b0);
    cyc(1);
    outs("lib.c2", 1'b0, 1'b0, 3'd3, 1'b1, 1'b0);
    cyc(2);
    outs("lib.c4", 1'b0, 1'b0, 3'd3, 1'b1, 1'b0);
    cyc(1);
    outs("lib.gap1", 1'b0, 1'b0, 3'd3, 1'b0, 1'b0);
    cyc(2);
    outs("lib.gap3", 1'b0, 1'b0, 3'd3, 1'b0, 1'b0);
    cyc(1);
    outs("lib.regrant", 1'b1, 1'b0, 3'd3, 1'b1, 1'b0);
    libre_req = 1'b0;
    cyc(8);

    // Simultaneous requests: free-play first, sequencer 7 cycles later.
    libre_req = 1'b1; libre_nota = 3'd1;
    sec_req = 1'b1; sec_nota = 3'd5;
    cyc(1);
    outs("both.lib", 1'b1, 1'b0, 3'd1, 1'b1, 1'b0);
    libre_req = 1'b0;
    cyc(5);
    outs("both.hold", 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    cyc(1);
    outs("both.wait", 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    cyc(1);
    outs("both.sec", 1'b0, 1'b1, 3'd5, 1'b1, 1'b1);
    sec_req = 1'b0;
    cyc(8);

    // habilitar dropped mid-note: note completes, no new grant until it rises.
    libre_req = 1'b1; libre_nota = 3'd4;
    cyc(1);
    outs("hab.grant", 1'b1, 1'b0, 3'd4, 1'b1, 1'b0);
    cyc(1);
    habilitar = 1'b0;
    cyc(2);
    outs("hab.c4", 1'b0, 1'b0, 3'd4, 1'b1, 1'b0);
    cyc(1);
    outs("hab.end", 1'b0, 1'b0, 3'd4, 1'b0, 1'b0);
    cyc(3);
    outs("hab.low8", 1'b0, 1'b0, 3'd4, 1'b0, 1'b0);
    cyc(2);
    outs("hab.low10", 1'b0, 1'b0, 3'd4, 1'b0, 1'b0);
    habilitar = 1'b1;
    cyc(1);
    outs("hab.resume", 1'b1, 1'b0, 3'd4, 1'b1, 1'b0);
    libre_req = 1'b0;
    cyc(8);

    // Sequencer note 2; free-play note 6 requested in its 2nd cycle.
    sec_req = 1'b1; sec_nota = 3'd2;
    cyc(1);
    outs("pre.sec", 1'b0, 1'b1, 3'd2, 1'b1, 1'b1);
    sec_req = 1'b0;
    cyc(1);
    libre_req = 1'b1; libre_nota = 3'd6;
    cyc(1);
`ifdef PREEMPCION_EN
    outs("pre.take", 1'b1, 1'b0, 3'd6, 1'b1, 1'b0);
    libre_req = 1'b0;
    cyc(3);
    outs("pre.c4", 1'b0, 1'b0, 3'd6, 1'b1, 1'b0);
    cyc(1);
    outs("pre.end", 1'b0, 1'b0, 3'd6, 1'b0, 1'b0);
`else
    outs("nopre.c3", 1'b0, 1'b0, 3'd2, 1'b1, 1'b1);
    cyc(1);
    outs("nopre.c4", 1'b0, 1'b0, 3'd2, 1'b1, 1'b1);
    cyc(1);
    outs("nopre.end", 1'b0, 1'b0, 3'd2, 1'b0, 1'b1);
    cyc(2);
    outs("nopre.wait", 1'b0, 1'b0, 3'd2, 1'b0, 1'b1);
    cyc(1);
    outs("nopre.lib", 1'b1, 1'b0, 3'd6, 1'b1, 1'b0);
    libre_req = 1'b0;
`endif
    cyc(8);

    // Reset asserted mid-note clears outputs immediately.
    sec_req = 1'b1; sec_nota = 3'd5;
    cyc(1);
    outs("rst.grant", 1'b0, 1'b1, 3'd5, 1'b1, 1'b1);
    sec_req = 1'b0;
    cyc(1);
    #2;
    reset = 1'b0;
    #1;
    outs("rst.async", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    cyc(1);
    reset = 1'b1;
    cyc(3);
    outs("rst.idle", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    libre_req = 1'b1; libre_nota = 3'd7;
    cyc(1);
    outs("rst.after", 1'b1, 1'b0, 3'd7, 1'b1, 1'b0);
    libre_req = 1'b0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/planificador_notas.md
# planificador_notas

Note scheduler that shares the single tone-generator path between two requesters: the free-play FSM (player keystrokes) and the song sequencer (demo playback). It grants one note at a time and holds the generator for a fixed note duration followed by a fixed silence gap. It drives the `nota`/`contar` pair consumed by the tone generator and duration display. It sits between the mode FSMs and the audio datapath.

## Interface
- `DURACION`, 25_000_000, note length in clock cycles (≥1; 0.5 s at 50 MHz)
- `SILENCIO`, 2_500_000, gap after each note in clock cycles (≥1)
- `CW`, $clog2(max(DURACION,SILENCIO)+1), counter width (derived, not overridden)

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `habilitar`  in  1  high: new grants allowed; low: no new grants, current note/gap finishes
- `libre_req`  in  1  free-play request, level, held until `libre_ack`
- `libre_nota`  in  3  note code from free-play FSM, stable while `libre_req`
- `sec_req`  in  1  sequencer request, level, held until `sec_ack`
- `sec_nota`  in  3  note code from sequencer, stable while `sec_req`
- `libre_ack`  out  1  one-cycle grant pulse to free-play FSM
- `sec_ack`  out  1  one-cycle grant pulse to sequencer
- `nota`  out  3  note code to tone generator
- `contar`  out  1  high while a note sounds (tone generator enable)
- `fuente`  out  1  owner of current/last note: 0 free-play, 1 sequencer

## Operation
- States: REPOSO, SONANDO, PAUSA.
- REPOSO: if `habilitar` and any req, grant. Fixed priority: `libre_req` beats `sec_req`. On grant edge: `nota`←granted note, `fuente`←owner, `contar`←1, matching ack←1, counter←DURACION-1, →SONANDO.
- SONANDO: counter decrements each cycle; at counter==0: `contar`←0, counter←SILENCIO-1, →PAUSA.
- PAUSA: counter decrements; at counter==0 →REPOSO.
- Acks are registered, high exactly one cycle (first SONANDO cycle). Requester drops req on the cycle after ack or may hold it to request the next note.
- Both reqs in the same REPOSO cycle: libre granted; sec keeps waiting (no ack).
- `habilitar` low in SONANDO/PAUSA: no effect until REPOSO; then remain in REPOSO.
- `nota`, `fuente` hold their value after the note ends, until next grant.
- Counter is CW bits, unsigned, never wraps: load only on state entry, compare ==0.

## Timing
- Reset values: `nota`=0, `contar`=0, `fuente`=0, `libre_ack`=0, `sec_ack`=0, state REPOSO, counter 0. Reset mid-note aborts immediately (async); no ack re-issued.
- Grant latency: req sampled at edge k → ack/`contar` high after edge k.
- `contar` high exactly DURACION cycles, then low ≥ SILENCIO+1 cycles (PAUSA + one REPOSO cycle).
- Minimum note period with continuous requests: DURACION+SILENCIO+1 cycles.

## Configuration
- `PREEMPCION_EN` defined: in SONANDO with `fuente`=1, a `libre_req` (with `habilitar` high) regrants at the next edge: `nota`←`libre_nota`, `fuente`←0, `libre_ack` pulse, counter←DURACION-1, `contar` stays high; interrupted sequencer note is dropped. No preemption in PAUSA or of free-play notes.
- Not defined: free-play waits for REPOSO like any request.

## Structure
- Package `notas_pkg`: state enum (REPOSO, SONANDO, PAUSA), 3-bit note codes (DO=0 … SI=6, NINGUNA=7), owner constants LIBRE=0/SEC=1.
- Sub-module `contador_duracion`: CW-bit loadable down counter with `cargar`, `valor`, `cero` outputs; instantiated once.

## Test plan (DURACION=4, SILENCIO=2)
- Reset low mid-SONANDO → `contar`, acks, `nota` go 0 immediately; after release, state REPOSO, no grant without req.
- `libre_req`=1, `libre_nota`=3 → `libre_ack` one cycle, `nota`=3, `fuente`=0, `contar` high 4 cycles, low 3 cycles before next grant.
- `libre_req` and `sec_req` (nota 5) same cycle → libre granted first; sec acked 7 cycles later with `nota`=5, `fuente`=1.
- `habilitar` dropped during SONANDO → note completes 4 cycles, no further ack while low; grant resumes one cycle after `habilitar` rises.
- `PREEMPCION_EN`: sec note 2 sounding, `libre_req` nota 6 at its 2nd cycle → next edge `nota`=6, `fuente`=0, `libre_ack`, `contar` stays high 4 more cycles.
- Without `PREEMPCION_EN`, same stimulus → sec note plays full 4 cycles; libre acked after PAUSA+REPOSO.
